// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and command in, registered result,
// status flags and start/busy/done handshake out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       EXE_CMD;
  logic [WIDTH-1:0] Val1;
  logic [WIDTH-1:0] Val2;
  logic             C_in;
  logic             S;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             N_out;
  logic             Z_out;
  logic             C_out;
  logic             V_out;

  modport master (
    output start, EXE_CMD, Val1, Val2, C_in, S,
    input  busy, done, result, N_out, Z_out, C_out, V_out
  );

  modport slave (
    input  start, EXE_CMD, Val1, Val2, C_in, S,
    output busy, done, result, N_out, Z_out, C_out, V_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered EXE-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiply, with optional (S-gated) NZCV status update at completion.
module alu_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_mcand, w_mcand_n;
  logic [WIDTH-1:0] r_mplier, w_mplier_n;
  logic [WIDTH-1:0] r_acc, w_acc_n;
  logic [WIDTH-1:0] r_result, w_result_n;
  logic [CW-1:0]    r_count, w_count_n;
  logic             r_s, w_s_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_n, w_n_n;
  logic             r_z, w_z_n;
  logic             r_c, w_c_n;
  logic             r_v, w_v_n;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_mul_acc;

  // Single-cycle datapath; w_wr=0 means the command leaves result/flags untouched
  always_comb begin
    w_sum    = '0;
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_wr     = 1'b1;
    w_is_mul = 1'b0;
    case (bus.EXE_CMD)
      CMD_MOV: w_res = bus.Val2;
      CMD_MVN: w_res = ~bus.Val2;
      CMD_ADD, CMD_ADC: begin
        w_sum = {1'b0, bus.Val1} + {1'b0, bus.Val2}
              + (WIDTH+1)'((bus.EXE_CMD == CMD_ADC) ? bus.C_in : 1'b0);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.Val1[WIDTH-1] == bus.Val2[WIDTH-1]) &&
                (w_res[WIDTH-1] != bus.Val1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // a - b - ~cin == a + ~b + cin; the carry out is the inverted borrow
        w_sum = {1'b0, bus.Val1} + {1'b0, ~bus.Val2}
              + (WIDTH+1)'((bus.EXE_CMD == CMD_SBC) ? bus.C_in : 1'b1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.Val1[WIDTH-1] != bus.Val2[WIDTH-1]) &&
                (w_res[WIDTH-1] != bus.Val1[WIDTH-1]);
      end
      CMD_AND: w_res = bus.Val1 & bus.Val2;
      CMD_ORR: w_res = bus.Val1 | bus.Val2;
      CMD_EOR: w_res = bus.Val1 ^ bus.Val2;
      CMD_MUL: begin
        w_wr     = 1'b0;
        w_is_mul = (MUL_EN != 0);
      end
      default: w_wr = 1'b0;
    endcase
  end

  assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Next-state and next-output logic
  always_comb begin
    w_state_n  = r_state;
    w_mcand_n  = r_mcand;
    w_mplier_n = r_mplier;
    w_acc_n    = r_acc;
    w_result_n = r_result;
    w_count_n  = r_count;
    w_s_n      = r_s;
    w_busy_n   = r_busy;
    w_done_n   = 1'b0;
    w_n_n      = r_n;
    w_z_n      = r_z;
    w_c_n      = r_c;
    w_v_n      = r_v;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_is_mul) begin
            w_state_n  = ST_MUL;
            w_mcand_n  = bus.Val1;
            w_mplier_n = bus.Val2;
            w_s_n      = bus.S;
            w_acc_n    = '0;
            w_count_n  = '0;
            w_busy_n   = 1'b1;
          end else begin
            w_done_n = 1'b1;
            if (w_wr) begin
              w_result_n = w_res;
              if (bus.S) begin
                w_n_n = w_res[WIDTH-1];
                w_z_n = (w_res == '0);
                w_c_n = w_c;
                w_v_n = w_v;
              end
            end
          end
        end
      end
      ST_MUL: begin
        w_acc_n    = w_mul_acc;
        w_mcand_n  = r_mcand << 1;
        w_mplier_n = r_mplier >> 1;
        w_count_n  = r_count + CW'(1);
        if (r_count == CW'(WIDTH - 1)) begin
          w_state_n  = ST_IDLE;
          w_busy_n   = 1'b0;
          w_done_n   = 1'b1;
          w_result_n = w_mul_acc;
          if (r_s) begin
            w_n_n = w_mul_acc[WIDTH-1];
            w_z_n = (w_mul_acc == '0);
            w_c_n = 1'b0;
            w_v_n = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_s      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_mcand  <= w_mcand_n;
      r_mplier <= w_mplier_n;
      r_acc    <= w_acc_n;
      r_result <= w_result_n;
      r_count  <= w_count_n;
      r_s      <= w_s_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_n      <= w_n_n;
      r_z      <= w_z_n;
      r_c      <= w_c_n;
      r_v      <= w_v_n;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.N_out  = r_n;
  assign bus.Z_out  = r_z;
  assign bus.C_out  = r_c;
  assign bus.V_out  = r_v;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): vector table of back-to-back single-cycle
// ops, then hand-written multiply, ignored-start, S-gating and mid-multiply reset cases.
module tb_alu_seq;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] v1;
    logic [W-1:0] v2;
    logic         cin;
    logic         s;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nzcv();
    return {bus.N_out, bus.Z_out, bus.C_out, bus.V_out};
  endfunction

  task automatic drive(input logic st, input logic [3:0] cmd, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic s);
    bus.start   = st;
    bus.EXE_CMD = cmd;
    bus.Val1    = a;
    bus.Val2    = b;
    bus.C_in    = cin;
    bus.S       = s;
  endtask

  // Start a MUL, then count edges until busy drops (bounded)
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int n);
    drive(1'b1, 4'b1010, a, b, 1'b0, s);
    step();
    drive(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'b0010, 32'd1,          32'd2,          1'b0, 1'b1, 32'd3,          4'b0000};
    vecs[1]  = '{4'b0010, 32'h7FFF_FFFF,  32'd1,          1'b0, 1'b1, 32'h8000_0000,  4'b1001};
    vecs[2]  = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b1, 32'h0,          4'b0110};
    vecs[3]  = '{4'b0100, 32'd3,          32'd5,          1'b0, 1'b1, 32'hFFFF_FFFE,  4'b1000};
    vecs[4]  = '{4'b0101, 32'd5,          32'd3,          1'b0, 1'b1, 32'd1,          4'b0010};
    vecs[5]  = '{4'b0011, 32'd1,          32'd2,          1'b1, 1'b1, 32'd4,          4'b0000};
    vecs[6]  = '{4'b0100, 32'd5,          32'd3,          1'b0, 1'b1, 32'd2,          4'b0010};
    vecs[7]  = '{4'b0001, 32'd9,          32'd0,          1'b0, 1'b0, 32'd0,          4'b0010};
    vecs[8]  = '{4'b1001, 32'd0,          32'd0,          1'b0, 1'b1, 32'hFFFF_FFFF,  4'b1000};
    vecs[9]  = '{4'b0110, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  1'b0, 1'b1, 32'h00F0_00F0,  4'b0000};
    vecs[10] = '{4'b0111, 32'h0F00_0000,  32'h0000_00F0,  1'b0, 1'b1, 32'h0F00_00F0,  4'b0000};
    vecs[11] = '{4'b1000, 32'hFFFF_0000,  32'hFF00_FF00,  1'b0, 1'b1, 32'h00FF_FF00,  4'b0000};
    vecs[12] = '{4'b0100, 32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF,  4'b0011};
    vecs[13] = '{4'b0000, 32'd1,          32'd1,          1'b1, 1'b1, 32'h7FFF_FFFF,  4'b0011};
    vecs[14] = '{4'b1111, 32'd1,          32'd1,          1'b1, 1'b1, 32'h7FFF_FFFF,  4'b0011};
    vecs[15] = '{4'b0010, 32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1, 32'h0,          4'b0111};

    // Reset held with a pending start
    rst = 1'b1;
    drive(1'b1, 4'b0010, 32'd1, 32'd2, 1'b0, 1'b1);
    #2 rst = 1'b0;
    step();
    step();
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags",  64'(nzcv()),     64'd0);
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    rst = 1'b1;

    // Back-to-back single-cycle table: start stays high every cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].cmd, vecs[i].v1, vecs[i].v2, vecs[i].cin, vecs[i].s);
      step();
      check($sformatf("vec%0d_result", i), 64'(bus.result), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i),  64'(nzcv()),     64'(vecs[i].nzcv));
      check($sformatf("vec%0d_done", i),   64'(bus.done),   64'd1);
    end
    drive(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0);
    step();
    check("idle_done", 64'(bus.done), 64'd0);

    // MUL 12x13 with an ignored MOV start mid-flight
    drive(1'b1, 4'b1010, 32'd12, 32'd13, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0);
    check("mul_busy_start", 64'(bus.busy), 64'd1);
    check("mul_done_start", 64'(bus.done), 64'd0);
    n = 0;
    while (bus.busy && n < 100) begin
      if (n == 10) drive(1'b1, 4'b0001, 32'd0, 32'd7, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0);
      n++;
      if (n == 20) begin
        check("mul_mid_result", 64'(bus.result), 64'd0);
        check("mul_mid_flags",  64'(nzcv()),     64'b0111);
        check("mul_mid_done",   64'(bus.done),   64'd0);
      end
    end
    check("mul_latency", 64'(n),          64'd32);
    check("mul_result",  64'(bus.result), 64'd156);
    check("mul_done",    64'(bus.done),   64'd1);
    check("mul_flags",   64'(nzcv()),     64'b0000);
    step();
    check("mul_done_pulse", 64'(bus.done),   64'd0);
    check("mul_hold",       64'(bus.result), 64'd156);

    // Product wraps to zero
    run_mul(32'h0001_0000, 32'h0001_0000, 1'b1, n);
    check("mulz_latency", 64'(n),          64'd32);
    check("mulz_result",  64'(bus.result), 64'd0);
    check("mulz_flags",   64'(nzcv()),     64'b0100);

    // S=0 multiply: result written, flags hold
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
    check("mulns_result", 64'(bus.result), 64'd1);
    check("mulns_flags",  64'(nzcv()),     64'b0100);
    check("mulns_done",   64'(bus.done),   64'd1);

    // Reset at iteration 10 abandons the multiply
    drive(1'b1, 4'b1010, 32'd3, 32'd4, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    rst = 1'b0;
    #1;
    check("rstmul_busy",   64'(bus.busy),   64'd0);
    check("rstmul_result", 64'(bus.result), 64'd0);
    check("rstmul_flags",  64'(nzcv()),     64'd0);
    step();
    step();
    check("rstmul_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    step();
    check("rstmul_idle_done", 64'(bus.done), 64'd0);
    run_mul(32'd3, 32'd4, 1'b1, n);
    check("postrst_latency", 64'(n),          64'd32);
    check("postrst_result",  64'(bus.result), 64'd12);
    check("postrst_flags",   64'(nzcv()),     64'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the execute-stage ALU.
- Adds a multi-cycle shift-add multiply, a start/busy/done handshake, registered result and status flags, and a conditional status-flag update (S bit).
- Sits in the EXE stage. The hazard unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, datapath width in bits (min 4).
- MUL_EN, 1, 1 = MUL command implemented; 0 = MUL decodes as an unknown command.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  request; accepted only when busy=0.
- EXE_CMD  in  4  operation code, sampled on an accepted start.
- Val1  in  WIDTH  operand 1, sampled on an accepted start.
- Val2  in  WIDTH  operand 2, sampled on an accepted start.
- C_in  in  1  carry input (ADC/SBC), sampled on an accepted start.
- S  in  1  1 = update status flags when the operation completes; sampled on an accepted start.
- busy  out  1  high while a multiply iterates.
- done  out  1  one-cycle pulse in the cycle after result is written.
- result  out  WIDTH  registered result.
- N_out, Z_out, C_out, V_out  out  1 each  registered status flags.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, result=0, all flags=0.
  - Iteration counter and accumulator are cleared.
  - A multiply in flight is abandoned; no done pulse is generated for it.
- Encoding, with C/V results:
  - 0001 MOV = Val2; C=0, V=0.
  - 1001 MVN = ~Val2; C=0, V=0.
  - 0010 ADD = Val1+Val2.
  - 0011 ADC = Val1+Val2+C_in.
  - 0100 SUB = Val1-Val2.
  - 0101 SBC = Val1-Val2-(~C_in).
  - 0110 AND, 0111 ORR, 1000 EOR; C=0, V=0.
  - 1010 MUL = low WIDTH bits of Val1*Val2; C=0, V=0.
  - Any other code = NOP.
- Arithmetic rules:
  - Internal sums are WIDTH+1 bits wide.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC: C = NOT borrow (ARM convention): SUB 5-3 gives C=1, SUB 3-5 gives C=0.
  - V = signed overflow computed from the MSBs of the operands and the result.
  - N = result[WIDTH-1]; Z = (result == 0).
- Single-cycle ops, IDLE state:
  - An accepted start writes result at the next rising edge; done=1 for exactly the following cycle.
  - Latency is 1.
  - Back-to-back starts are legal on every cycle; done stays high continuously.
- NOP:
  - done pulses as for a single-cycle op.
  - result and flags hold their previous values.
- MUL (MUL_EN=1):
  - An accepted start moves IDLE->MUL: multiplicand, multiplier, S latched; accumulator=0; count=0; busy=1 from the next cycle.
  - Each cycle in MUL: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - On the edge where count==WIDTH-1: result = accumulator (including the final add); state->IDLE; busy=0; done=1 in the next cycle.
  - Total latency from the accepting edge to result valid is WIDTH cycles.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight.
- Flags:
  - Written only at completion, and only if the latched S=1.
  - If S=0, flags hold; result is still written.
  - Flags never change mid-multiply.
- Outputs change only on clk edges or async reset; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst=0 with start=1 → all outputs 0. Release; start ADD Val1=1, Val2=2, S=1 → next cycle result=3, done=1, NZCV=0000.
- Carry/overflow (WIDTH=32), ADD S=1: 0x7FFFFFFF+1 → result 0x80000000, N=1, V=1, C=0. 0xFFFFFFFF+1 → 0, Z=1, C=1.
- Borrow: SUB 3-5 → 0xFFFFFFFE, N=1, C=0. SBC 5-3 with C_in=0 → 1, C=1.
- Multiply: MUL 12×13, S=1 → busy for 32 cycles, result=156 at cycle 32, then done pulse. A start(MOV 7) issued mid-multiply is ignored. 0x10000×0x10000 → result 0, Z=1.
- S gating and back-to-back: MOV 0 with S=0 after a flag-setting op → result 0, flags unchanged. Three consecutive single-cycle starts → three consecutive results, done high for 3 cycles.
- Reset mid-MUL: assert rst=0 at iteration 10 → immediate clear, no done pulse. After release, a new MUL completes correctly.
